// File: rtl/aes_v3_colseq.sv
// aes_v3_colseq: column sequencer around an external single-byte AES unit.
// It walks the four bytes of a 32-bit state column through the byte unit
// and XOR-accumulates each partial result onto a seed word (for example a
// round-key word). Supported operations are SubBytes-only, MixColumns-only
// and, when enabled, the combined Sub-then-Mix sequence.
//
// Optional feature macro: AES_V3_COLSEQ_FULL_EN
//   defined   -> op 2'b10 runs Sub then Mix per byte, using a tmp register
//   undefined -> op 2'b10 is reported as reserved and tmp is not built
module aes_v3_colseq (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic        in_dec,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rd,
    output logic        out_err,
    output logic        u_valid,
    output logic        u_dec,
    output logic        u_mix,
    output logic [1:0]  u_bs,
    output logic [31:0] u_rs1,
    input  logic [31:0] u_rd
);

    localparam logic [1:0] OP_SUB  = 2'b00;
    localparam logic [1:0] OP_MIX  = 2'b01;
    localparam logic [1:0] OP_FULL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SUB  = 2'b01,
        S_MIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // An op is reserved when it has no sequence behind it in this build.
    function automatic logic op_is_reserved(input logic [1:0] op);
        logic res;
        case (op)
            OP_SUB:  res = 1'b0;
            OP_MIX:  res = 1'b0;
`ifdef AES_V3_COLSEQ_FULL_EN
            OP_FULL: res = 1'b0;
`else
            OP_FULL: res = 1'b1;
`endif
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    state_t      state_q;
    logic        dec_q;
    logic [31:0] rs1_q;
    logic [31:0] acc_q;
    logic [1:0]  bs_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        out_err_q;
    logic [31:0] out_rd_q;
`ifdef AES_V3_COLSEQ_FULL_EN
    logic [31:0] tmp_q;
    logic        full_q;
`endif

    logic [31:0] acc_d;
    logic [1:0]  bs_d;
    logic        last_s;
    logic        full_s;

    // Next accumulator / byte-select values and the "last byte" condition.
    always_comb begin
        acc_d  = acc_q ^ u_rd;
        bs_d   = bs_q + 2'd1;
        last_s = (bs_q == 2'd3);
`ifdef AES_V3_COLSEQ_FULL_EN
        full_s = full_q;
`else
        full_s = 1'b0;
`endif
    end

    // Byte-unit drive, decoded from registered state; the operand is
    // forced to zero whenever the unit is not in use so it does not toggle.
    always_comb begin
        u_valid = 1'b0;
        u_mix   = 1'b0;
        u_rs1   = 32'h0000_0000;
        u_dec   = dec_q;
        u_bs    = bs_q;
        case (state_q)
            S_SUB: begin
                u_valid = 1'b1;
                u_mix   = 1'b0;
                u_rs1   = rs1_q;
            end
            S_MIX: begin
                u_valid = 1'b1;
                u_mix   = 1'b1;
`ifdef AES_V3_COLSEQ_FULL_EN
                if (full_s) begin
                    u_rs1 = tmp_q;
                end else begin
                    u_rs1 = rs1_q;
                end
`else
                u_rs1   = rs1_q;
`endif
            end
            default: begin
                u_valid = 1'b0;
                u_mix   = 1'b0;
                u_rs1   = 32'h0000_0000;
            end
        endcase
    end

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q     <= S_IDLE;
            dec_q       <= 1'b0;
            rs1_q       <= 32'h0000_0000;
            acc_q       <= 32'h0000_0000;
            bs_q        <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_rd_q    <= 32'h0000_0000;
`ifdef AES_V3_COLSEQ_FULL_EN
            tmp_q       <= 32'h0000_0000;
            full_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        dec_q      <= in_dec;
                        rs1_q      <= in_rs1;
                        acc_q      <= in_rs2;
                        bs_q       <= 2'd0;
                        in_ready_q <= 1'b0;
`ifdef AES_V3_COLSEQ_FULL_EN
                        full_q     <= (in_op == OP_FULL);
`endif
                        if (op_is_reserved(in_op)) begin
                            // Reserved ops skip the unit and return the seed.
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b1;
                            out_rd_q    <= in_rs2;
                        end else if (in_op == OP_MIX) begin
                            state_q <= S_MIX;
                        end else begin
                            state_q <= S_SUB;
                        end
                    end
                end
                S_SUB: begin
                    if (full_s) begin
                        // Combined op: park the substituted byte for the Mix step.
`ifdef AES_V3_COLSEQ_FULL_EN
                        tmp_q <= u_rd;
`endif
                        state_q <= S_MIX;
                    end else begin
                        acc_q <= acc_d;
                        bs_q  <= bs_d;
                        if (last_s) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b0;
                            out_rd_q    <= acc_d;
                        end else begin
                            state_q <= S_SUB;
                        end
                    end
                end
                S_MIX: begin
                    acc_q <= acc_d;
                    bs_q  <= bs_d;
                    if (last_s) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b0;
                        out_rd_q    <= acc_d;
                    end else if (full_s) begin
                        state_q <= S_SUB;
                    end else begin
                        state_q <= S_MIX;
                    end
                end
                S_DONE: begin
                    // Result is held until taken; in_ready rises one cycle
                    // after the handoff so no request slips in during it.
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        out_rd_q    <= 32'h0000_0000;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_err_q   <= 1'b0;
                    out_rd_q    <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;
    assign out_rd    = out_rd_q;

endmodule
